eth_tx_arbiter: RTL and testbench

Frame-atomic two-input arbiter sharing one TEMAC transmit AXI4-Stream between two byte-wide frame sources, e.g. frame-detector injected replies (source A) and traffic-generator output (source B). It sits between those sources and the `m_axis_*` transmit port of one Ethernet interface. Grants are round-robin per frame and never interleave bytes of two frames. A programmable idle gap is enforced after every frame.

---
 rtl/eth_tx_arbiter_pkg.sv | 6 +
 rtl/eth_tx_arbiter_counter.sv | 15 +
 rtl/eth_tx_arbiter.sv | 87 ++++++++
 tb/tb_eth_tx_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_arbiter_pkg.sv
// eth_tx_arbiter_pkg: state encoding and source-select constants for the transmit arbiter
package eth_tx_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, FWD_A, FWD_B, GAP} arb_state_t;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;
endpackage

// File: rtl/eth_tx_arbiter_counter.sv
// eth_tx_arbiter_counter: clearable wrapping event counter, clear wins over increment
module eth_tx_arbiter_counter #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             inc,
  output logic [width-1:0] count
);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) count <= '0;
    else if (clear) count <= '0;
    else if (inc) count <= count + width'(1);
endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: frame-atomic round-robin arbiter of two byte streams onto one TEMAC tx port
// ETH_TX_ARB_FRAME_COUNT_EN adds per-source completed-frame counters and the count_width parameter
module eth_tx_arbiter
  import eth_tx_arbiter_pkg::*;
#(
  parameter int ifg_width = 8
`ifdef ETH_TX_ARB_FRAME_COUNT_EN
  , parameter int count_width = 32
`endif
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic [ifg_width-1:0] ifg_cycles,
  input  logic [7:0]           s_axis_a_tdata,
  input  logic                 s_axis_a_tuser,
  input  logic                 s_axis_a_tlast,
  input  logic                 s_axis_a_tvalid,
  output logic                 s_axis_a_tready,
  input  logic [7:0]           s_axis_b_tdata,
  input  logic                 s_axis_b_tuser,
  input  logic                 s_axis_b_tlast,
  input  logic                 s_axis_b_tvalid,
  output logic                 s_axis_b_tready,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tuser,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
`ifdef ETH_TX_ARB_FRAME_COUNT_EN
  output logic [count_width-1:0] frames_a,
  output logic [count_width-1:0] frames_b,
  input  logic                   clear_counters,
`endif
  output logic                 grant_a,
  output logic                 grant_b
);
  arb_state_t state;
  logic last_grant;
  logic [ifg_width-1:0] gap_cnt;
  logic req_a, req_b, eof_a, eof_b;
  assign req_a = enable & s_axis_a_tvalid;
  assign req_b = enable & s_axis_b_tvalid;
  assign grant_a = state == FWD_A;
  assign grant_b = state == FWD_B;
  assign eof_a = grant_a & s_axis_a_tvalid & m_axis_tready & s_axis_a_tlast;
  assign eof_b = grant_b & s_axis_b_tvalid & m_axis_tready & s_axis_b_tlast;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      last_grant <= SRC_B;
    end else begin
      case (state)
        IDLE:
          if (req_a && (!req_b || last_grant == SRC_B)) state <= FWD_A;
          else if (req_b) state <= FWD_B;
        FWD_A, FWD_B:
          if (eof_a || eof_b) begin
            last_grant <= eof_b ? SRC_B : SRC_A;
            gap_cnt    <= ifg_cycles;
            state      <= ifg_cycles == '0 ? IDLE : GAP;
          end
        GAP: begin
          gap_cnt <= gap_cnt - ifg_width'(1);
          if (gap_cnt <= ifg_width'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  always_comb begin
    s_axis_a_tready = grant_a & m_axis_tready;
    s_axis_b_tready = grant_b & m_axis_tready;
    m_axis_tvalid   = grant_a ? s_axis_a_tvalid : grant_b & s_axis_b_tvalid;
    m_axis_tdata    = grant_a ? s_axis_a_tdata : grant_b ? s_axis_b_tdata : 8'h00;
    m_axis_tuser    = grant_a ? s_axis_a_tuser : grant_b & s_axis_b_tuser;
    m_axis_tlast    = grant_a ? s_axis_a_tlast : grant_b & s_axis_b_tlast;
  end
`ifdef ETH_TX_ARB_FRAME_COUNT_EN
  eth_tx_arbiter_counter #(.width(count_width)) u_cnt_a (
    .clk(clk), .resetn(resetn), .clear(clear_counters), .inc(eof_a), .count(frames_a)
  );
  eth_tx_arbiter_counter #(.width(count_width)) u_cnt_b (
    .clk(clk), .resetn(resetn), .clear(clear_counters), .inc(eof_b), .count(frames_b)
  );
`endif
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed frames with an expected-beat queue checked by a decoupled monitor
module tb_eth_tx_arbiter;
  typedef struct packed {logic src; logic [7:0] d; logic u; logic l;} beat_t;
  logic clk = 0, resetn = 0, enable = 0, m_ready = 1, clear = 0;
  logic [7:0] ifg = 0;
  logic [7:0] a_data = 0, b_data = 0;
  logic a_user = 0, a_last = 0, a_valid = 0, b_user = 0, b_last = 0, b_valid = 0;
  logic a_ready, b_ready, grant_a, grant_b;
  logic [7:0] m_axis_tdata;
  logic m_axis_tuser, m_axis_tlast, m_axis_tvalid;
`ifdef ETH_TX_ARB_FRAME_COUNT_EN
  logic [3:0] frames_a, frames_b;
`endif
  beat_t exp_q[$];
  beat_t got;
  int pass_cnt = 0, total_cnt = 0, viol = 0;

  eth_tx_arbiter #(
    .ifg_width(8)
`ifdef ETH_TX_ARB_FRAME_COUNT_EN
    , .count_width(4)
`endif
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .ifg_cycles(ifg),
    .s_axis_a_tdata(a_data), .s_axis_a_tuser(a_user), .s_axis_a_tlast(a_last),
    .s_axis_a_tvalid(a_valid), .s_axis_a_tready(a_ready),
    .s_axis_b_tdata(b_data), .s_axis_b_tuser(b_user), .s_axis_b_tlast(b_last),
    .s_axis_b_tvalid(b_valid), .s_axis_b_tready(b_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_ready),
`ifdef ETH_TX_ARB_FRAME_COUNT_EN
    .frames_a(frames_a), .frames_b(frames_b), .clear_counters(clear),
`endif
    .grant_a(grant_a), .grant_b(grant_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] outs();
    return 32'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, grant_a, grant_b, a_ready, b_ready});
  endfunction

  task automatic push_frame(input logic src, input logic [7:0] base, input int len, input int upto);
    for (int i = 0; i < upto; i++) begin
      logic [7:0] d;
      d = base + 8'(i);
      exp_q.push_back(beat_t'({src, d, d[1], i == len - 1}));
    end
  endtask

  task automatic drive(input logic src, input logic v, input logic [7:0] d, input logic l);
    if (src) begin b_valid = v; b_data = d; b_user = d[1]; b_last = l; end
    else begin a_valid = v; a_data = d; a_user = d[1]; a_last = l; end
  endtask

  task automatic wait_rdy(input logic src, output logic ok);
    int t;
    t = 0;
    @(negedge clk);
    while (!(src ? b_ready : a_ready) && t < 400) begin t++; @(negedge clk); end
    ok = t < 400;
    if (!ok) check("ready_timeout", 32'(t), 0);
  endtask

  task automatic send(input logic src, input logic [7:0] base, input int len, input int hole, input logic clr);
    logic ok;
    for (int i = 0; i < len; i++) begin
      if (i == hole) begin drive(src, 0, 0, 0); repeat (2) @(posedge clk); #1; end
      drive(src, 1, base + 8'(i), i == len - 1);
      wait_rdy(src, ok);
      if (!ok) break;
      if (clr && i == len - 1) clear = 1;
      @(posedge clk); #1;
      clear = 0;
    end
    drive(src, 0, 0, 0);
  endtask

  task automatic measure(output int n, input logic poke);
    n = 0;
    @(negedge clk);
    while (!grant_a && n < 100) begin
      n++;
      if (poke && n == 5) ifg = 2;
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if ((grant_a && grant_b) || (grant_b && a_ready) || (grant_a && b_ready)) viol++;
    if (m_axis_tvalid && m_ready) begin
      if (exp_q.size() == 0) check("unexpected_beat", 32'(m_axis_tdata), 32'hffff_ffff);
      else begin
        got = exp_q.pop_front();
        check("beat", 32'({grant_b, m_axis_tdata, m_axis_tuser, m_axis_tlast}), 32'(got));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, t;
    logic ok;
    repeat (3) @(posedge clk); #1;
    check("reset_outputs", outs(), 0);
    resetn = 1;
    drive(0, 1, 8'h10, 0);
    repeat (3) @(negedge clk);
    check("enable_low_no_grant", 32'(grant_a), 0);
    @(posedge clk); #1;
    enable = 1;
    push_frame(0, 8'h10, 4, 4);
    @(negedge clk);
    check("grant_cycle_n", 32'(grant_a), 0);
    @(negedge clk);
    check("grant_cycle_n1", 32'(grant_a), 1);
    @(posedge clk); #1;
    send(0, 8'h11, 3, -1, 0);
`ifdef ETH_TX_ARB_FRAME_COUNT_EN
    check("frames_a_single", 32'(frames_a), 1);
`endif
    push_frame(0, 8'h50, 3, 3);
    push_frame(0, 8'h58, 3, 3);
    send(0, 8'h50, 3, -1, 0);
    fork
      send(0, 8'h58, 3, -1, 0);
      measure(n, 0);
    join
    check("ifg0_dead_cycles", 32'(n), 1);
    ifg = 12;
    push_frame(0, 8'h60, 3, 3);
    push_frame(0, 8'h68, 3, 3);
    send(0, 8'h60, 3, -1, 0);
    fork
      send(0, 8'h68, 3, -1, 0);
      measure(n, 1);
    join
    check("ifg12_dead_cycles", 32'(n), 13);
    ifg = 0;
    push_frame(1, 8'h20, 5, 5);
    push_frame(0, 8'h30, 3, 3);
    fork
      send(1, 8'h20, 5, 2, 0);
      send(0, 8'h30, 3, -1, 0);
      begin
        logic [3:0] pat;
        pat = 4'b1001;
        for (int i = 0; i < 16; i++) begin m_ready = pat[i % 4]; @(posedge clk); #1; end
        m_ready = 1;
      end
    join
    check("a_blocked_during_b", 32'(viol), 0);
    push_frame(1, 8'h70, 2, 2);
    send(1, 8'h70, 2, -1, 0);
    push_frame(0, 8'hA0, 2, 2);
    push_frame(1, 8'hB0, 2, 2);
    push_frame(0, 8'hA4, 2, 2);
    push_frame(1, 8'hB4, 2, 2);
    push_frame(0, 8'hA8, 3, 3);
    push_frame(1, 8'hB8, 3, 3);
    fork
      begin send(0, 8'hA0, 2, -1, 0); send(0, 8'hA4, 2, -1, 0); send(0, 8'hA8, 3, -1, 0); end
      begin send(1, 8'hB0, 2, -1, 0); send(1, 8'hB4, 2, -1, 0); send(1, 8'hB8, 3, -1, 0); end
    join
    push_frame(0, 8'hC0, 10, 2);
    drive(0, 1, 8'hC0, 0); wait_rdy(0, ok); @(posedge clk); #1;
    drive(0, 1, 8'hC1, 0); wait_rdy(0, ok); @(posedge clk); #1;
    drive(0, 1, 8'hC2, 0); #1;
    resetn = 0; #1;
    check("reset_midframe_outputs", outs(), 0);
    drive(0, 0, 0, 0);
    push_frame(1, 8'hD0, 3, 3);
    fork
      send(1, 8'hD0, 3, -1, 0);
      begin repeat (3) @(posedge clk); #1; resetn = 1; end
    join
    @(posedge clk); #1;
    resetn = 0;
    push_frame(0, 8'hE0, 2, 2);
    push_frame(1, 8'hE8, 2, 2);
    fork
      send(0, 8'hE0, 2, -1, 0);
      send(1, 8'hE8, 2, -1, 0);
      begin repeat (2) @(posedge clk); #1; resetn = 1; end
    join
`ifdef ETH_TX_ARB_FRAME_COUNT_EN
    check("frames_a_after_reset", 32'(frames_a), 1);
    check("frames_b_after_reset", 32'(frames_b), 1);
    for (int i = 0; i < 14; i++) begin
      push_frame(0, 8'h80 + 8'(i), 1, 1);
      send(0, 8'h80 + 8'(i), 1, -1, 0);
    end
    check("frames_a_max", 32'(frames_a), 15);
    push_frame(0, 8'h8F, 1, 1);
    send(0, 8'h8F, 1, -1, 0);
    check("frames_a_wrap", 32'(frames_a), 0);
    push_frame(1, 8'h90, 2, 2);
    send(1, 8'h90, 2, -1, 1);
    check("frames_b_clear_wins", 32'(frames_b), 0);
`endif
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin @(negedge clk); t++; end
    check("queue_drain", 32'(exp_q.size()), 0);
    check("exclusive_grants", 32'(viol), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
